// File: rtl/banco_registradores_param.sv
// Parametrised register file with hardwired zero register, busy scoreboard and debug read port.
// Optional same-cycle write-to-read bypass on ports A/B when WRITE_BYPASS_EN is defined.
module banco_registradores_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_set_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_count
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam bit              ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              set_ok;
    logic              set_adds;
    logic              clr_subs;

    assign wr_ok  = wr_en && !(ZERO_EN && (wr_addr == '0));
    assign set_ok = busy_set && !(ZERO_EN && (busy_set_addr == '0));

    // A set only grows the count if the entry was idle; a clear only shrinks it
    // if the entry was pending and is not being re-issued on the same edge.
    assign set_adds = set_ok && !busy[busy_set_addr];
    assign clr_subs = wr_ok && busy[wr_addr] && !(set_ok && (busy_set_addr == wr_addr));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so a same-address issue keeps the entry pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[wr_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy[busy_set_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_count <= '0;
        end else if (set_adds && !clr_subs) begin
            busy_count <= busy_count + CNT_ONE;
        end else if (!set_adds && clr_subs) begin
            busy_count <= busy_count - CNT_ONE;
        end
    end

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        busy_a    = busy[rd_addr_a];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            busy_a    = busy_set && (busy_set_addr == rd_addr_a);
        end
`endif
        if (ZERO_EN && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            busy_a    = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = mem[rd_addr_b];
        busy_b    = busy[rd_addr_b];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            busy_b    = busy_set && (busy_set_addr == rd_addr_b);
        end
`endif
        if (ZERO_EN && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            busy_b    = 1'b0;
        end
    end

    always_comb begin
        dbg_data = mem[dbg_addr];
        if (ZERO_EN && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
Parametrised register file: successor to the fixed 32x32 bank. Generalised in data width and depth, with an asynchronous active-low reset clearing all entries. Adds a hardwired zero register, a per-entry busy scoreboard for multicycle writebacks, and an independent debug read port. Sits in the decode stage: read ports feed operand muxes, the write port comes from writeback, busy flags feed the stall logic.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes/busy sets; 0 = entry 0 is an ordinary register

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rd_addr_a  in  ADDR_W  read port A address (rs)
rd_addr_b  in  ADDR_W  read port B address (rt)
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data (never bypassed)
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
busy_set  in  1  mark busy_set_addr pending (multicycle op issued)
busy_set_addr  in  ADDR_W  entry to mark pending
busy_a  out  1  pending flag for rd_addr_a
busy_b  out  1  pending flag for rd_addr_b
busy_count  out  ADDR_W+1  number of entries currently pending

Behaviour:
- Reset: clock and reset_n are as named above; reset is asynchronous and active-low. While reset_n=0, all 2**ADDR_W entries clear to 0 and all busy bits clear to 0 immediately, independent of clock. Outputs then read 0, busy_a/busy_b=0, busy_count=0. Reset dominates any write or busy_set in the same cycle.
- Write: at rising edge with wr_en=1, mem[wr_addr] <= wr_data. New value is visible on read ports from the following cycle, or the same cycle with the optional feature.
- Reads: rd_data_a/b and dbg_data are combinational from addresses. No latency.
- Zero register (ZERO_REG=1): reads of address 0 return 0 on every port. Writes to 0 are dropped. busy_set to 0 is dropped. busy flag 0 is always 0.
- Scoreboard: per-entry busy bit.
  - Set at rising edge when busy_set=1.
  - Cleared at rising edge when wr_en=1 to that address.
  - Same edge, same address, both set and clear: set wins; the bit stays 1 for the new issue.
  - busy_set to an already-busy entry: no change (idempotent).
  - wr_en to a non-busy entry: write occurs, busy unchanged.
  - busy_a = busy[rd_addr_a]; busy_b = busy[rd_addr_b].
- busy_count: registered population count of busy bits, updated each edge consistently with the busy vector (+1, -1, or 0 net). Range 0..2**ADDR_W; never wraps.
- Both read ports at the same address: identical data and busy.

Optional Feature:
Macro WRITE_BYPASS_EN.
- Defined: if wr_en=1 and wr_addr equals rd_addr_a (or rd_addr_b), that port returns wr_data in the same cycle. Its busy output reports 0 unless busy_set targets the same address in that cycle. Zero-register rule overrides the bypass. dbg_data is never bypassed.
- Undefined: read ports return the stored value only; the written value appears the cycle after the edge, and busy outputs reflect stored bits only.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pull reset_n low mid-cycle without a clock edge -> rd_data_a(r5)=0 immediately, busy_count=0.
- Write/read: wr_en, r7=0x12345678 -> next cycle rd_data_a(r7)=rd_data_b(r7)=dbg_data(r7)=0x12345678. A write of 0xFFFFFFFF to r0 with ZERO_REG=1 -> r0 reads 0.
- Scoreboard: busy_set r3 -> busy_a(r3)=1, busy_count=1. Then busy_set r3 and wr_en r3 on the same edge -> busy stays 1, count stays 1. Then wr_en r3 alone -> busy 0, count 0.
- Fill: busy_set every entry 1..31 over 31 cycles (ZERO_REG=1) -> busy_count=31. busy_set r0 -> count stays 31.
- Bypass (WRITE_BYPASS_EN): r9 busy, wr_en r9=0xA5A5A5A5 with rd_addr_a=9 -> same-cycle rd_data_a=0xA5A5A5A5, busy_a=0, dbg_data(r9) shows the old value. Without the macro -> old value and busy_a=1 that cycle.
- Width parameter: DATA_W=16, ADDR_W=3 -> write 0xBEEF to r7, read 0xBEEF. busy_count width is 4 and saturates at 7 with ZERO_REG=1.
